// File: rtl/vx_reset_sequencer_pkg.sv
// Shared types and defaults for the cluster reset sequencer: FSM state encoding
// and the parameter defaults used by the top and its interface.
package vx_reset_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } seq_state_t;

  localparam int DEF_N           = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_HOLD_CYCLES = 16;
  localparam int DEF_STAGGER     = 4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/vx_reset_sequencer_if.sv
// Sequencer-side signal bundle: soft-reset request in, per-domain resets, ready
// and the FSM state (for checkers) out.
interface vx_reset_sequencer_if
  import vx_reset_sequencer_pkg::*;
#(
  parameter int N = DEF_N
);

  // soft_req is a single-cycle level pulse, sampled on clk only while ready is high;
  // there is no ready/valid handshake, a request outside RUN is dropped.
  logic         soft_req;
  logic [N-1:0] reset_o;
  logic         ready;
  seq_state_t   dbg_state;

  modport master (
    output soft_req,
    input  reset_o,
    input  ready,
    input  dbg_state
  );

  modport slave (
    input  soft_req,
    output reset_o,
    output ready,
    output dbg_state
  );

endinterface

// File: rtl/vx_reset_sequencer_sync.sv
// Async-assert / sync-deassert chain: sync_rel drops immediately with resetn and
// rises SYNC_STAGES clk edges after resetn is released.
module vx_reset_sequencer_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  output logic sync_rel
);

  logic [SYNC_STAGES-1:0] chain_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sync_rel = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/vx_reset_sequencer.sv
// Cluster root reset: holds every domain in reset for HOLD_CYCLES after a
// synchronized release, then frees domains one by one every STAGGER cycles.
module vx_reset_sequencer
  import vx_reset_sequencer_pkg::*;
#(
  parameter int N           = DEF_N,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int STAGGER     = DEF_STAGGER
) (
  input  logic                  clk,
  input  logic                  resetn,
  vx_reset_sequencer_if.slave   rs
);

  localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, STAGGER)) + 1;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N - 1);

  logic sync_rel;

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             done_q, done_d;
  logic [N-1:0]     reset_q, reset_d;
  logic             ready_q, ready_d;

  vx_reset_sequencer_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .resetn   (resetn),
    .sync_rel (sync_rel)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      reset_q <= '1;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      reset_q <= reset_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    done_d  = done_q;
    reset_d = reset_q;
    ready_d = ready_q;

    case (state_q)
      ST_HOLD: begin
        if (sync_rel) begin
          if (cnt_q == HOLD_LAST) begin
            state_d = ST_RELEASE;
            cnt_d   = '0;
            idx_d   = '0;
            done_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_RELEASE: begin
        // done_q marks the trailing stagger slot after the last domain's wrap;
        // ready (and RUN) arrive one full STAGGER after the last release.
        if (done_q) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
          cnt_d   = '0;
          done_d  = 1'b0;
        end else begin
          if (cnt_q == '0) begin
            for (int i = 0; i < N; i++) begin
              if (idx_q == IDX_W'(i)) reset_d[i] = 1'b0;
            end
          end
          if (cnt_q == STAG_LAST) begin
            cnt_d = '0;
            if (idx_q == IDX_LAST) done_d = 1'b1;
            else                   idx_d  = idx_q + IDX_W'(1);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_RUN: begin
        // Soft reset reuses HOLD; the synchronizer stays released so counting starts at once.
        if (rs.soft_req) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
          idx_d   = '0;
          done_d  = 1'b0;
          reset_d = '1;
          ready_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_HOLD;
        cnt_d   = '0;
        idx_d   = '0;
        done_d  = 1'b0;
        reset_d = '1;
        ready_d = 1'b0;
      end
    endcase
  end

  assign rs.reset_o   = reset_q;
  assign rs.ready     = ready_q;
  assign rs.dbg_state = state_q;

endmodule

// File: tb/tb_vx_reset_sequencer.sv
// Bench for vx_reset_sequencer: two instances (N=4 and N=1) checked every cycle
// against a timing-formula model of domain release, ready and state.
module tb_vx_reset_sequencer;
  import vx_reset_sequencer_pkg::*;

  // Configurations: index 0 = main (N=4,S=2,H=8,ST=3), index 1 = minimal (N=1,S=2,H=1,ST=1)
  int p_n  [2] = '{4, 1};
  int p_s  [2] = '{2, 2};
  int p_h  [2] = '{8, 1};
  int p_st [2] = '{3, 1};

  logic clk;
  logic resetn;

  int errors = 0;
  int checks = 0;

  // Model: edges since the last release point, and the edge index at which domain 0 falls.
  int e      [2];
  int base   [2];
  bit active [2];

  vx_reset_sequencer_if #(.N(4)) rs0 ();
  vx_reset_sequencer_if #(.N(1)) rs1 ();

  vx_reset_sequencer #(
    .N (4), .SYNC_STAGES (2), .HOLD_CYCLES (8), .STAGGER (3)
  ) dut0 (
    .clk    (clk),
    .resetn (resetn),
    .rs     (rs0.slave)
  );

  vx_reset_sequencer #(
    .N (1), .SYNC_STAGES (2), .HOLD_CYCLES (1), .STAGGER (1)
  ) dut1 (
    .clk    (clk),
    .resetn (resetn),
    .rs     (rs1.slave)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [3:0] exp_rst(int d);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < p_n[d]; i++) begin
      r[i] = !active[d] || (e[d] < base[d] + i * p_st[d]);
    end
    return r;
  endfunction

  function automatic logic exp_rdy(int d);
    return active[d] && (e[d] >= base[d] + p_n[d] * p_st[d]);
  endfunction

  function automatic seq_state_t exp_state(int d);
    if (!active[d])            return ST_HOLD;
    if (exp_rdy(d))            return ST_RUN;
    if (e[d] >= base[d] - 1)   return ST_RELEASE;
    return ST_HOLD;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ph);
    check($sformatf("%s_rst0",   ph), {28'd0, rs0.reset_o},   {28'd0, exp_rst(0)});
    check($sformatf("%s_rdy0",   ph), {31'd0, rs0.ready},     {31'd0, exp_rdy(0)});
    check($sformatf("%s_st0",    ph), {30'd0, rs0.dbg_state}, {30'd0, exp_state(0)});
    check($sformatf("%s_rst1",   ph), {31'd0, rs1.reset_o},   {28'd0, exp_rst(1)});
    check($sformatf("%s_rdy1",   ph), {31'd0, rs1.ready},     {31'd0, exp_rdy(1)});
    check($sformatf("%s_st1",    ph), {30'd0, rs1.dbg_state}, {30'd0, exp_state(1)});
  endtask

  // ---------------- driver tasks ----------------
  // One clock edge: model advances on the posedge, outputs compared on the negedge.
  task automatic step(input string ph);
    bit sr [2];
    sr[0] = rs0.soft_req;
    sr[1] = rs1.soft_req;
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (active[d]) begin
        if (sr[d] && exp_rdy(d)) begin
          e[d]    = 0;
          base[d] = p_h[d] + 1;
        end else begin
          e[d]++;
        end
      end
    end
    @(negedge clk);
    check_all(ph);
  endtask

  task automatic activate();
    for (int d = 0; d < 2; d++) begin
      active[d] = 1'b1;
      e[d]      = 0;
      base[d]   = p_s[d] + p_h[d] + 1;
    end
  endtask

  // Called at a negedge: pulse resetn low mid-cycle, check the asynchronous effect,
  // hold for low_edges clock edges (0 = glitch with no edge) and release before the next posedge.
  task automatic pulse_reset(input int low_edges, input string ph);
    #1 resetn = 1'b0;
    active[0] = 1'b0;
    active[1] = 1'b0;
    #1 check_all({ph, "_async"});
    if (low_edges == 0) begin
      #1 resetn = 1'b1;
    end else begin
      repeat (low_edges) step({ph, "_low"});
      resetn = 1'b1;
    end
    activate();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    resetn      = 1'b0;
    rs0.soft_req = 1'b0;
    rs1.soft_req = 1'b0;
    active[0] = 1'b0;
    active[1] = 1'b0;
    e[0] = 0; e[1] = 0;
    base[0] = 0; base[1] = 0;

    // Reset state
    @(negedge clk);
    #1 check_all("por");
    repeat (3) step("por");

    // Plain power-up sequence: E1..E30
    resetn = 1'b1;
    activate();
    repeat (30) step("seq");

    // Soft reset in RUN on both instances
    rs0.soft_req = 1'b1;
    rs1.soft_req = 1'b1;
    step("soft_edge");
    rs0.soft_req = 1'b0;
    rs1.soft_req = 1'b0;
    repeat (25) step("soft");

    // resetn pulsed mid-RELEASE (after E15), then full restart with soft_req held
    // through HOLD/RELEASE and onto the ready-rise edge E23, where it must be ignored.
    pulse_reset(1, "rst");
    repeat (15) step("mid");
    pulse_reset(2, "midrel");
    rs0.soft_req = 1'b1;
    repeat (23) step("held");
    rs0.soft_req = 1'b0;
    repeat (6) step("held_after");

    // Sub-period glitch with no clock edge during it
    pulse_reset(0, "glitch");
    repeat (26) step("glitch_seq");

    // Randomized soft requests and occasional resetn pulses
    for (int k = 0; k < 300; k++) begin
      rs0.soft_req = ($urandom_range(0, 11) == 0);
      rs1.soft_req = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 79) == 0) begin
        rs0.soft_req = 1'b0;
        rs1.soft_req = 1'b0;
        pulse_reset($urandom_range(0, 2), "rnd");
      end
      step("rnd");
    end
    rs0.soft_req = 1'b0;
    rs1.soft_req = 1'b0;
    repeat (30) step("drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vx_reset_sequencer.md
Name: VX_reset_sequencer

Overview:
Root reset source for a cluster; its outputs feed the per-unit reset fan-out relays.
- Takes the board-level asynchronous active-low reset and synchronizes its deassertion to clk.
- Holds all reset domains asserted for a programmable interval, then releases N domains one at a time with a fixed stagger to limit inrush and simultaneous-start hazards.
- Supports a synchronous soft-reset request once the system is running.

Parameters:
N, 4, number of staggered reset domains (>=1)
SYNC_STAGES, 2, flops in the deassertion synchronizer (>=2)
HOLD_CYCLES, 16, cycles all domains stay asserted after synchronized release (>=1)
STAGGER, 4, cycles between consecutive domain releases (>=1)

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset; assertion is asynchronous, deassertion is synchronized internally
soft_req  input  1  single-cycle soft-reset request; sampled only in RUN
reset_o  output  N  active-high per-domain resets, registered; domain i released in index order
ready  output  1  high when all domains are released (state RUN)

Behaviour:
- Interface decision: one clock (clk); reset is asynchronous and active-low (resetn).
- resetn low forces the following immediately, independent of clk, from any state including mid-RELEASE:
  - reset_o = all ones, ready = 0, state = HOLD;
  - counters = 0, domain index = 0, synchronizer chain = 0.
- Synchronizer:
  - Shifts 1 in on each clk edge while resetn is high.
  - sync_rel goes high after SYNC_STAGES edges.
  - HOLD counting is gated until sync_rel is high.
- States: HOLD, RELEASE, RUN.
- HOLD: cnt increments each edge while sync_rel. On the edge where cnt == HOLD_CYCLES-1, transition to RELEASE with cnt = 0 and idx = 0.
- RELEASE:
  - On the edge where cnt == 0, reset_o[idx] is cleared.
  - cnt counts 0..STAGGER-1 and then wraps.
  - On wrap: idx++. When idx == N-1 wraps, transition to RUN and set ready = 1.
- Timing, with edge E1 = first clk edge after resetn deasserts:
  - reset_o[i] falls at edge E(SYNC_STAGES + HOLD_CYCLES + 1 + i*STAGGER).
  - ready rises at edge E(SYNC_STAGES + HOLD_CYCLES + 1 + N*STAGGER).
- Released domains stay released; reset_o bits never re-assert except via resetn or a soft reset.
- RUN: soft_req high on edge Ek causes, after Ek:
  - reset_o = all ones, ready = 0, state = HOLD, cnt = 0.
  - The synchronizer is not re-run: sync_rel stays high.
  - reset_o[i] falls at Ek + HOLD_CYCLES + 1 + i*STAGGER.
- soft_req is ignored in HOLD/RELEASE; it is not queued.
- soft_req on the same edge that sets ready is ignored, because the state is not yet RUN.
- Counter width: CLOG2(max(HOLD_CYCLES, STAGGER)) + 1.
- idx width: max(1, CLOG2(N)).
- No wrap-around beyond these limits.
- N == 1: a single release, followed by ready STAGGER cycles later.

Decomposition:
- Shared package VX_reset_pkg:
  - State typedef enum (HOLD, RELEASE, RUN).
  - Default parameter constants.
- Sub-module VX_reset_sync: the async-assert / sync-deassert chain (clk, resetn -> sync_rel, SYNC_STAGES parameter). Reused by other blocks needing a synchronized release.
- Remaining FSM and counters live in VX_reset_sequencer.

Test Plan:
- Parameters N=4, SYNC_STAGES=2, HOLD_CYCLES=8, STAGGER=3. resetn low then high before E1 -> reset_o[0..3] fall at E11, E14, E17, E20; ready rises at E23; reset_o = 4'b1111 through E10.
- resetn pulsed low between E15 and E16 (mid-RELEASE) -> reset_o = 4'b1111 and ready = 0 asynchronously; on release, the full sequence restarts from the new E1.
- In RUN, soft_req for one cycle at edge Ek -> reset_o = 4'b1111 and ready = 0 after Ek; reset_o[0] falls at Ek+9, reset_o[3] at Ek+18; ready rises at Ek+21.
- soft_req held high during HOLD and RELEASE -> no effect, timing identical to the first scenario; soft_req asserted on the ready-rise edge is ignored.
- N=1, HOLD_CYCLES=1, STAGGER=1, SYNC_STAGES=2 -> reset_o falls at E4, ready rises at E5.
- resetn glitch asserted for less than one clk period with no clk edge during it -> outputs still assert asynchronously and recover via the full sequence.
